// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings and constants for the pipeline stall sequencer and its hazard comparator.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    StRun    = 2'd0,
    StStall  = 2'd1,
    StFreeze = 2'd2
  } seq_state_e;

  localparam logic [4:0] REG_ZERO     = 5'd0;
  localparam logic [1:0] LU_BR_STALL  = 2'd2;
  localparam logic [1:0] SINGLE_STALL = 2'd1;

  // $0 never carries a dependency.
  function automatic logic reg_match(input logic [4:0] field, input logic [4:0] rs,
                                     input logic [4:0] rt);
    return (field != REG_ZERO) && ((field == rs) || (field == rt));
  endfunction

endpackage

// File: rtl/hazard_match.sv
// Combinational comparator flagging load-use and branch-operand dependencies for the ID stage.
module hazard_match
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] if_id_rs_i,
  input  logic [4:0] if_id_rt_i,
  input  logic [4:0] id_ex_rt_i,
  input  logic [4:0] id_ex_rd_i,
  input  logic [4:0] ex_mem_rd_i,
  input  logic       id_ex_memread_i,
  input  logic       id_ex_regwrite_i,
  input  logic       ex_mem_memread_i,
  input  logic       id_branch_i,
  output logic       lu_o,
  output logic       br_alu_o,
  output logic       br_ld_o
);

  always_comb begin
    lu_o     = id_ex_memread_i & reg_match(id_ex_rt_i, if_id_rs_i, if_id_rt_i);
    br_alu_o = id_branch_i & id_ex_regwrite_i & reg_match(id_ex_rd_i, if_id_rs_i, if_id_rt_i);
    br_ld_o  = id_branch_i & ex_mem_memread_i & reg_match(ex_mem_rd_i, if_id_rs_i, if_id_rt_i);
  end

endmodule

// File: rtl/pipeline_stall_sequencer.sv
// Pipeline-control sequencer: hazard stalls, branch/jump flushes and data-memory freezes.
// Optional saturating performance counters are built when PIPE_PERF_CNT_EN is defined.
module pipeline_stall_sequencer
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       if_id_rs,
  input  logic [4:0]       if_id_rt,
  input  logic [4:0]       id_ex_rt,
  input  logic [4:0]       id_ex_rd,
  input  logic [4:0]       ex_mem_rd,
  input  logic             id_ex_memread,
  input  logic             id_ex_regwrite,
  input  logic             ex_mem_memread,
  input  logic             id_branch,
  input  logic             id_branch_taken,
  input  logic             id_jump,
  input  logic             dmem_busy,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             id_ex_bubble,
  output logic             if_flush,
  output logic             pipe_hold,
  output logic             mem_timeout_err,
`ifdef PIPE_PERF_CNT_EN
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count,
  output logic [CNT_W-1:0] freeze_cycles,
`endif
  output logic [1:0]       seq_state
);

  localparam int unsigned WaitW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WaitW-1:0] WaitMax = WaitW'(MEM_TIMEOUT);

  seq_state_e       state_q, state_d, ret_q, ret_d, run_state;
  logic [1:0]       cnt_q, cnt_d, stall_len;
  logic [WaitW-1:0] wait_q, wait_d;
  logic             err_q, err_d;
  logic             lu, br_alu, br_ld;

  hazard_match u_hazard_match (
    .if_id_rs_i       (if_id_rs),
    .if_id_rt_i       (if_id_rt),
    .id_ex_rt_i       (id_ex_rt),
    .id_ex_rd_i       (id_ex_rd),
    .ex_mem_rd_i      (ex_mem_rd),
    .id_ex_memread_i  (id_ex_memread),
    .id_ex_regwrite_i (id_ex_regwrite),
    .ex_mem_memread_i (ex_mem_memread),
    .id_branch_i      (id_branch),
    .lu_o             (lu),
    .br_alu_o         (br_alu),
    .br_ld_o          (br_ld)
  );

  always_comb begin
    stall_len = 2'd0;
    if (lu && id_branch) begin
      stall_len = LU_BR_STALL;
    end else if (lu || br_alu || br_ld) begin
      stall_len = SINGLE_STALL;
    end
  end

  always_comb begin
    state_d      = state_q;
    ret_d        = ret_q;
    cnt_d        = cnt_q;
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    id_ex_bubble = 1'b0;
    if_flush     = 1'b0;
    pipe_hold    = 1'b0;
    // A cycle in FREEZE with memory ready already behaves as the resumed state.
    run_state    = (state_q == StFreeze) ? ret_q : state_q;

    if (dmem_busy) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      pipe_hold   = 1'b1;
      state_d     = StFreeze;
      ret_d       = (run_state == StStall) ? StStall : StRun;
    end else begin
      case (run_state)
        StRun: begin
          if (stall_len != 2'd0) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
            cnt_d        = stall_len - 2'd1;
            state_d      = (cnt_d != 2'd0) ? StStall : StRun;
          end else begin
            if_flush = id_jump | (id_branch & id_branch_taken);
            state_d  = StRun;
          end
        end
        StStall: begin
          pc_write     = 1'b0;
          if_id_write  = 1'b0;
          id_ex_bubble = 1'b1;
          cnt_d        = (cnt_q != 2'd0) ? cnt_q - 2'd1 : 2'd0;
          state_d      = (cnt_q <= 2'd1) ? StRun : StStall;
        end
        default: begin
          state_d = StRun;
          cnt_d   = 2'd0;
        end
      endcase
    end

    if (!rst_n) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_bubble = 1'b1;
      if_flush     = 1'b1;
      pipe_hold    = 1'b0;
    end
  end

  always_comb begin
    wait_d = '0;
    if (dmem_busy) begin
      wait_d = (wait_q == WaitMax) ? wait_q : wait_q + 1'b1;
    end
    err_d = err_q | (wait_d == WaitMax);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StRun;
      ret_q   <= StRun;
      cnt_q   <= 2'd0;
      wait_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      cnt_q   <= cnt_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
    end
  end

  assign mem_timeout_err = err_q;
  assign seq_state       = state_q;

`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q, freeze_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q  <= '0;
      flush_cnt_q  <= '0;
      freeze_cnt_q <= '0;
    end else begin
      if (id_ex_bubble && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 1'b1;
      if (if_flush && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + 1'b1;
      if (pipe_hold && (freeze_cnt_q != '1)) freeze_cnt_q <= freeze_cnt_q + 1'b1;
    end
  end

  assign stall_cycles  = stall_cnt_q;
  assign flush_count   = flush_cnt_q;
  assign freeze_cycles = freeze_cnt_q;
`else
  logic unused_cnt_w;
  assign unused_cnt_w = |CNT_W;
`endif

endmodule

// File: tb/tb_pipeline_stall_sequencer.sv
// Directed scoreboard bench for pipeline_stall_sequencer; covers PIPE_PERF_CNT_EN when defined.
module tb_pipeline_stall_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] if_id_rs, if_id_rt, id_ex_rt, id_ex_rd, ex_mem_rd;
  logic       id_ex_memread, id_ex_regwrite, ex_mem_memread;
  logic       id_branch, id_branch_taken, id_jump, dmem_busy;
  logic       pc_write, if_id_write, id_ex_bubble, if_flush, pipe_hold, mem_timeout_err;
  logic [1:0] seq_state;
`ifdef PIPE_PERF_CNT_EN
  logic [3:0] stall_cycles, flush_count, freeze_cycles;
`endif

  always #5 clk = ~clk;

  pipeline_stall_sequencer #(
    .MEM_TIMEOUT (16),
    .CNT_W       (4)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .if_id_rs        (if_id_rs),
    .if_id_rt        (if_id_rt),
    .id_ex_rt        (id_ex_rt),
    .id_ex_rd        (id_ex_rd),
    .ex_mem_rd       (ex_mem_rd),
    .id_ex_memread   (id_ex_memread),
    .id_ex_regwrite  (id_ex_regwrite),
    .ex_mem_memread  (ex_mem_memread),
    .id_branch       (id_branch),
    .id_branch_taken (id_branch_taken),
    .id_jump         (id_jump),
    .dmem_busy       (dmem_busy),
    .pc_write        (pc_write),
    .if_id_write     (if_id_write),
    .id_ex_bubble    (id_ex_bubble),
    .if_flush        (if_flush),
    .pipe_hold       (pipe_hold),
    .mem_timeout_err (mem_timeout_err),
`ifdef PIPE_PERF_CNT_EN
    .stall_cycles    (stall_cycles),
    .flush_count     (flush_count),
    .freeze_cycles   (freeze_cycles),
`endif
    .seq_state       (seq_state)
  );

  typedef struct {
    string      tag;
    logic [7:0] exp;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  wire [7:0] obs = {pc_write, if_id_write, id_ex_bubble, if_flush, pipe_hold, mem_timeout_err,
                    seq_state};

  // Packs {pc_write, if_id_write, bubble, flush, hold, err, state}.
  function automatic logic [7:0] ex(input logic pc, input logic fi, input logic bu,
                                    input logic fl, input logic ho, input logic er,
                                    input logic [1:0] st);
    return {pc, fi, bu, fl, ho, er, st};
  endfunction

  task automatic push(input string tag, input logic [7:0] e);
    exp_t item;
    item.tag = tag;
    item.exp = e;
    sb_q.push_back(item);
  endtask

  task automatic compare_now();
    exp_t e;
    e = sb_q.pop_front();
    n_cmp++;
    assert (obs === e.exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", e.tag, obs, e.exp);
    end
  endtask

  task automatic step(input string tag, input logic [7:0] e);
    push(tag, e);
    @(negedge clk);
    compare_now();
    @(posedge clk);
    #1;
  endtask

  task automatic check_val(input string tag, input logic [3:0] o, input logic [3:0] e);
    n_cmp++;
    assert (o === e)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, o, e);
    end
  endtask

  task automatic clr();
    if_id_rs = 5'd0; if_id_rt = 5'd0; id_ex_rt = 5'd0; id_ex_rd = 5'd0; ex_mem_rd = 5'd0;
    id_ex_memread = 1'b0; id_ex_regwrite = 1'b0; ex_mem_memread = 1'b0;
    id_branch = 1'b0; id_branch_taken = 1'b0; id_jump = 1'b0; dmem_busy = 1'b0;
  endtask

  task automatic lw_beq();
    clr();
    id_ex_memread = 1'b1; id_ex_rt = 5'd2; if_id_rs = 5'd2;
    id_branch = 1'b1; id_branch_taken = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    clr();
    step("reset_outputs", ex(0, 0, 1, 1, 0, 0, 0));
    rst_n = 1'b1;
    step("idle_run", ex(1, 1, 0, 0, 0, 0, 0));

    // Load-use: single stall, stays in RUN.
    id_ex_memread = 1'b1; id_ex_rt = 5'd2; if_id_rs = 5'd2;
    step("lu_stall", ex(0, 0, 1, 0, 0, 0, 0));
    clr();
    step("lu_resume", ex(1, 1, 0, 0, 0, 0, 0));

    // Load feeding a taken branch: two stall cycles, no flush until re-evaluated.
    lw_beq();
    step("lubr_stall1", ex(0, 0, 1, 0, 0, 0, 0));
    step("lubr_stall2", ex(0, 0, 1, 0, 0, 0, 1));
    clr(); id_branch = 1'b1; id_branch_taken = 1'b1;
    step("lubr_flush", ex(1, 1, 0, 1, 0, 0, 0));
    clr();
    step("lubr_done", ex(1, 1, 0, 0, 0, 0, 0));

    // ALU result feeding a taken branch via rt.
    id_ex_regwrite = 1'b1; id_ex_rd = 5'd5; if_id_rt = 5'd5;
    id_branch = 1'b1; id_branch_taken = 1'b1;
    step("bralu_stall", ex(0, 0, 1, 0, 0, 0, 0));
    id_ex_regwrite = 1'b0; id_ex_rd = 5'd0;
    step("bralu_flush", ex(1, 1, 0, 1, 0, 0, 0));
    clr();
    step("bralu_flush_once", ex(1, 1, 0, 0, 0, 0, 0));

    // Load in MEM feeding a not-taken branch, and the same load with no branch.
    ex_mem_memread = 1'b1; ex_mem_rd = 5'd7; if_id_rs = 5'd7; id_branch = 1'b1;
    step("brld_stall", ex(0, 0, 1, 0, 0, 0, 0));
    id_branch = 1'b0;
    step("brld_nobranch", ex(1, 1, 0, 0, 0, 0, 0));

    // $0 never creates a hazard; a jump flushes for exactly one cycle.
    clr(); id_ex_memread = 1'b1; id_ex_regwrite = 1'b1; id_branch = 1'b1;
    step("zero_reg", ex(1, 1, 0, 0, 0, 0, 0));
    clr(); id_jump = 1'b1;
    step("jump_flush", ex(1, 1, 0, 1, 0, 0, 0));
    clr();
    step("jump_once", ex(1, 1, 0, 0, 0, 0, 0));

    // Three-cycle freeze inside a two-cycle stall.
    lw_beq();
    step("frz_stall1", ex(0, 0, 1, 0, 0, 0, 0));
    dmem_busy = 1'b1;
    step("frz_hold1", ex(0, 0, 0, 0, 1, 0, 1));
    step("frz_hold2", ex(0, 0, 0, 0, 1, 0, 2));
    step("frz_hold3", ex(0, 0, 0, 0, 1, 0, 2));
    dmem_busy = 1'b0;
    step("frz_stall2", ex(0, 0, 1, 0, 0, 0, 2));
    clr(); id_branch = 1'b1; id_branch_taken = 1'b1;
    step("frz_flush", ex(1, 1, 0, 1, 0, 0, 0));
    clr();

    // 15 busy cycles stay below the timeout.
    dmem_busy = 1'b1;
    for (int i = 0; i < 15; i++) step("busy15", ex(0, 0, 0, 0, 1, 0, (i == 0) ? 2'd0 : 2'd2));
    dmem_busy = 1'b0;
    step("busy15_no_err", ex(1, 1, 0, 0, 0, 0, 2));
    step("busy15_run", ex(1, 1, 0, 0, 0, 0, 0));

    // 16 busy cycles trip the sticky timeout.
    dmem_busy = 1'b1;
    for (int i = 0; i < 16; i++) step("busy16", ex(0, 0, 0, 0, 1, 0, (i == 0) ? 2'd0 : 2'd2));
    dmem_busy = 1'b0;
    step("timeout_set", ex(1, 1, 0, 0, 0, 1, 2));
    step("timeout_sticky", ex(1, 1, 0, 0, 0, 1, 0));

    // Asynchronous reset in the middle of a stall.
    lw_beq();
    step("rst_stall1", ex(0, 0, 1, 0, 0, 1, 0));
    push("rst_stall2", ex(0, 0, 1, 0, 0, 1, 1));
    @(negedge clk);
    compare_now();
    #1 rst_n = 1'b0;
    #1 push("async_reset", ex(0, 0, 1, 1, 0, 0, 0));
    compare_now();
    @(posedge clk);
    #1;
    step("reset_held", ex(0, 0, 1, 1, 0, 0, 0));
    rst_n = 1'b1;
    clr();
    step("post_reset", ex(1, 1, 0, 0, 0, 0, 0));

`ifdef PIPE_PERF_CNT_EN
    rst_n = 1'b0;
    #1;
    check_val("perf_reset_stall", stall_cycles, 4'd0);
    rst_n = 1'b1;
    id_ex_memread = 1'b1; id_ex_rt = 5'd3; if_id_rt = 5'd3;
    for (int i = 0; i < 20; i++) step("perf_stall", ex(0, 0, 1, 0, 0, 0, 0));
    clr();
    dmem_busy = 1'b1;
    step("perf_freeze", ex(0, 0, 0, 0, 1, 0, 0));
    dmem_busy = 1'b0;
    check_val("perf_stall_sat", stall_cycles, 4'd15);
    check_val("perf_flush_cnt", flush_count, 4'd0);
    check_val("perf_freeze_cnt", freeze_cycles, 4'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/pipeline_stall_sequencer.md
Name: pipeline_stall_sequencer

Overview:
- Central pipeline-control sequencer for the 5-stage MIPS core.
- Detects load-use and branch-operand hazards in ID, then schedules multi-cycle stalls with a down-counter.
- Issues IF flushes for taken branches and jumps, and freezes the whole pipeline while data memory is busy.
- Drives the PC, IF/ID, ID/EX and downstream stage-register enables.

Parameters:
- MEM_TIMEOUT, 16: consecutive dmem_busy cycles after which mem_timeout_err sets.
- CNT_W, 16: width of the performance counters (optional feature only).

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- if_id_rs  in  5  rs field of the instruction in ID
- if_id_rt  in  5  rt field of the instruction in ID
- id_ex_rt  in  5  rt field (load destination) in EX
- id_ex_rd  in  5  write-register (post RegDst mux) in EX
- ex_mem_rd  in  5  write-register in MEM
- id_ex_memread  in  1  EX instruction is a load
- id_ex_regwrite  in  1  EX instruction writes a register
- ex_mem_memread  in  1  MEM instruction is a load
- id_branch  in  1  ID instruction is beq/bne
- id_branch_taken  in  1  ID comparator result
- id_jump  in  1  ID instruction is j/jal
- dmem_busy  in  1  data memory not ready this cycle
- pc_write  out  1  PC load enable
- if_id_write  out  1  IF/ID load enable
- id_ex_bubble  out  1  zero ID/EX control fields
- if_flush  out  1  clear IF/ID to nop
- pipe_hold  out  1  hold ID/EX, EX/MEM and MEM/WB
- mem_timeout_err  out  1  sticky memory-timeout flag
- seq_state  out  2  current FSM state

Behaviour:
- Hazard terms. A register field matches when it is nonzero and equals if_id_rs or if_id_rt.
  - lu = id_ex_memread & match(id_ex_rt)
  - br_alu = id_branch & id_ex_regwrite & match(id_ex_rd)
  - br_ld = id_branch & ex_mem_memread & match(ex_mem_rd)
- Required stall length N, computed in the RUN state:
  - lu & id_branch gives N=2.
  - Otherwise lu | br_alu | br_ld gives N=1.
  - Otherwise N=0.
- FSM states (encoding): RUN=0, STALL=1, FREEZE=2. Encoding 3 is illegal and recovers to RUN on the next clock.
- RUN state:
  - With N>0: outputs pc_write=0, if_id_write=0, id_ex_bubble=1 in the same cycle. Load cnt=N-1; go to STALL if cnt>0, else stay in RUN.
  - With N=0 and (id_jump | id_branch & id_branch_taken): if_flush=1 for one cycle; PC and IF/ID enables stay 1.
  - Otherwise all enables are 1, bubble=0, flush=0.
- STALL state: same outputs as a RUN stall. Hazard inputs are ignored. cnt decrements each cycle; leave to RUN when cnt reaches 0, after the cycle in which it was 1.
- FREEZE state:
  - Entered from any state whenever dmem_busy=1; that cycle's outputs already reflect the freeze.
  - Outputs: pc_write=0, if_id_write=0, pipe_hold=1, id_ex_bubble=0, if_flush=0.
  - The return state and cnt are saved and not decremented.
  - On dmem_busy=0, resume the saved state with the saved cnt.
- Priority: dmem_busy > stall > flush. A taken branch with a dependency stalls and does not flush; it is re-evaluated after the stall.
- Timeout: a wait counter increments on every freeze cycle and clears when not frozen. When it reaches MEM_TIMEOUT, set mem_timeout_err; it clears only on reset.
- Reset:
  - While rst_n=0: state=RUN, cnt=0, wait=0, err=0.
  - Outputs: pc_write=0, if_id_write=0, id_ex_bubble=1, if_flush=1, pipe_hold=0.
  - Reset asserted in the middle of a stall or freeze abandons it immediately.

Optional Feature:
- Macro: PIPE_PERF_CNT_EN.
- When defined, add outputs stall_cycles, flush_count and freeze_cycles, each CNT_W bits:
  - saturating counters, not wrapping;
  - counted per stall cycle, per if_flush pulse and per freeze cycle respectively;
  - reset to 0.
- When undefined, these ports and registers do not exist and the rest of the block behaves identically.

Decomposition:
- Shared package pipe_ctrl_pkg holds:
  - the state encodings RUN, STALL, FREEZE;
  - the REG_ZERO=5'd0 constant;
  - the stall-length constants LU_BR_STALL=2 and SINGLE_STALL=1.
- One natural sub-module, hazard_match, is a combinational field comparator producing lu, br_alu and br_ld.

Test Plan:
- lw $2 in EX (id_ex_memread=1, id_ex_rt=2), add using rs=2 in ID -> one cycle of pc_write=0 / id_ex_bubble=1, then RUN.
- lw $2 in EX, beq rs=2 in ID -> two consecutive stall cycles (seq_state goes 0 to 1 to 0), no if_flush.
- add writing $5 in EX, beq rt=5 taken -> one stall, then if_flush=1 for exactly one cycle once the branch is re-evaluated.
- Registers $0 in all fields with id_ex_memread=1 -> no stall; id_jump=1 -> if_flush=1 for one cycle.
- dmem_busy held 3 cycles in the middle of a 2-cycle stall -> pipe_hold=1 for 3 cycles, then the remaining stall cycle completes. Also: dmem_busy held 16 cycles -> mem_timeout_err=1 and stays set until rst_n=0.
- rst_n dropped during STALL -> state=RUN asynchronously with the reset output values; with PIPE_PERF_CNT_EN and CNT_W=4, 20 stalls -> stall_cycles=15.
